// File: rtl/eth_tx_sched.sv
// Purpose : three-port TX scheduler; round-robin grant, registered byte mux, IFG and watchdog.
// Latency : i_req -> o_gnt 1 cycle; i_en[g]/i_data[g] -> o_tx_en/o_data 1 cycle.
// Backpr. : none on the data path; a requester holds i_req until its o_gnt bit is seen.
//
// Ports:
//   eth_tx_clk, rst_n          clock, asynchronous active-low reset
//   i_req[2:0]                 per-port request level (0 ARP resp, 1 ARP req, 2 UDP)
//   o_gnt[2:0]                 one-hot registered grant, high for the whole frame
//   i_data0..2 / i_en0..2      per-port TX byte and data-valid
//   o_data / o_tx_en           registered byte and enable to the PHY
//   o_busy                     scheduler not in IDLE
//   o_err_cnt                  saturating count of start timeouts and frame aborts
module eth_tx_sched #(
   parameter int IFG_CYCLES       = 12,
   parameter int START_TIMEOUT    = 64,
   parameter int MAX_FRAME_CYCLES = 1600
) (
   input  logic       eth_tx_clk,
   input  logic       rst_n,
   input  logic [2:0] i_req,
   output logic [2:0] o_gnt,
   input  logic [7:0] i_data0,
   input  logic [7:0] i_data1,
   input  logic [7:0] i_data2,
   input  logic       i_en0,
   input  logic       i_en1,
   input  logic       i_en2,
   output logic [7:0] o_data,
   output logic       o_tx_en,
   output logic       o_busy,
   output logic [7:0] o_err_cnt
);

   localparam int MAX_A = (IFG_CYCLES > START_TIMEOUT) ? IFG_CYCLES : START_TIMEOUT;
   localparam int MAX_P = (MAX_A > MAX_FRAME_CYCLES) ? MAX_A : MAX_FRAME_CYCLES;
   localparam int CW    = $clog2(MAX_P + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      XMIT  = 2'd2,
      IFG   = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [1:0]    rr_last, rr_nxt, pick;
   logic [2:0]    gnt_nxt;
   logic [7:0]    data_nxt, err_nxt;
   logic          tx_en_nxt, err_inc;
   logic [7:0]    sel_data;
   logic          sel_en, sel_req;
   logic          start_hit, frame_hit, ifg_hit;

   // rr_last always names the port currently holding the grant, so it doubles
   // as the mux select; requests and enables from other ports never get through.
   always_comb begin
      sel_data = 8'h00;
      sel_en   = 1'b0;
      sel_req  = 1'b0;
      case (rr_last)
         2'd0:    begin sel_data = i_data0; sel_en = i_en0; sel_req = i_req[0]; end
         2'd1:    begin sel_data = i_data1; sel_en = i_en1; sel_req = i_req[1]; end
         2'd2:    begin sel_data = i_data2; sel_en = i_en2; sel_req = i_req[2]; end
         default: ;
      endcase
   end

   // First requester after rr_last, searching rr_last+1, +2, +3 (mod 3).
   always_comb begin
      pick = 2'd0;
      case (rr_last)
         2'd0:    pick = i_req[1] ? 2'd1 : (i_req[2] ? 2'd2 : 2'd0);
         2'd1:    pick = i_req[2] ? 2'd2 : (i_req[0] ? 2'd0 : 2'd1);
         default: pick = i_req[0] ? 2'd0 : (i_req[1] ? 2'd1 : 2'd2);
      endcase
   end

   // cnt counts cycles spent in the current state, starting at 0 on entry.
   assign start_hit = (cnt == CW'(START_TIMEOUT - 1));
   assign frame_hit = (cnt == CW'(MAX_FRAME_CYCLES - 1));
   assign ifg_hit   = (cnt == CW'(IFG_CYCLES - 1));

   // State and output registers
   always_ff @(posedge eth_tx_clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         rr_last   <= 2'd2;
         o_gnt     <= 3'b000;
         o_data    <= 8'h00;
         o_tx_en   <= 1'b0;
         o_err_cnt <= 8'h00;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         rr_last   <= rr_nxt;
         o_gnt     <= gnt_nxt;
         o_data    <= data_nxt;
         o_tx_en   <= tx_en_nxt;
         o_err_cnt <= err_nxt;
      end
   end

   // Next state; in GRANT a first byte beats both withdrawal and timeout, and in
   // XMIT a falling i_en beats the frame limit so a full-length frame is clean.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (|i_req) state_nxt = GRANT;
         GRANT: begin
            if (sel_en)         state_nxt = XMIT;
            else if (!sel_req)  state_nxt = IDLE;
            else if (start_hit) state_nxt = IFG;
         end
         XMIT:  if (!sel_en || frame_hit) state_nxt = IFG;
         IFG:   if (ifg_hit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      gnt_nxt   = o_gnt;
      rr_nxt    = rr_last;
      data_nxt  = 8'h00;
      tx_en_nxt = 1'b0;
      err_inc   = 1'b0;
      case (state)
         IDLE: begin
            if (|i_req) begin
               gnt_nxt = 3'b001 << pick;
               rr_nxt  = pick;
            end
         end
         GRANT: begin
            if (sel_en) begin
               // The enabling byte itself is forwarded so nothing is dropped.
               tx_en_nxt = 1'b1;
               data_nxt  = sel_data;
            end else if (!sel_req) begin
               gnt_nxt = 3'b000;
            end else if (start_hit) begin
               gnt_nxt = 3'b000;
               err_inc = 1'b1;
            end
         end
         XMIT: begin
            if (!sel_en) begin
               // The low o_tx_en registered here is the first IFG cycle.
               gnt_nxt = 3'b000;
            end else if (frame_hit) begin
               gnt_nxt = 3'b000;
               err_inc = 1'b1;
            end else begin
               tx_en_nxt = 1'b1;
               data_nxt  = sel_data;
            end
         end
         default: ;
      endcase
      cnt_nxt = (state_nxt != state || state == IDLE) ? '0 : cnt + CW'(1);
      err_nxt = (err_inc && o_err_cnt != 8'hFF) ? o_err_cnt + 8'h01 : o_err_cnt;
   end

   assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_eth_tx_sched.sv
module tb_eth_tx_sched;

   logic       clk;
   logic       rst_n;
   logic [2:0] req;
   logic [2:0] en;
   logic [7:0] dat [3];
   logic [2:0] o_gnt;
   logic [7:0] o_data;
   logic       o_tx_en;
   logic       o_busy;
   logic [7:0] o_err_cnt;

   eth_tx_sched dut (
      .eth_tx_clk (clk),
      .rst_n      (rst_n),
      .i_req      (req),
      .o_gnt      (o_gnt),
      .i_data0    (dat[0]),
      .i_data1    (dat[1]),
      .i_data2    (dat[2]),
      .i_en0      (en[0]),
      .i_en1      (en[1]),
      .i_en2      (en[2]),
      .o_data     (o_data),
      .o_tx_en    (o_tx_en),
      .o_busy     (o_busy),
      .o_err_cnt  (o_err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] req;
      int         l0, l1, l2;
      logic [2:0] hold, stray;
      int         exp_first, exp_frames, exp_len, exp_gap, exp_err_inc;
   } vec_t;

   int checks = 0;
   int errors = 0;

   // sender model state and monitor state
   int         len [3];
   int         sent [3];
   logic [2:0] hold, stray, prev_gnt;
   int         cyc, run, low_run, frames, last_len, min_gap, byte_err, bad_gnt;
   int         first_gnt_cyc, first_tx_cyc, req_cyc;
   int         gnt_log [$];

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] pat(input int p, input int i);
      logic [1:0] pp;
      logic [5:0] ii;
      pp = p[1:0];
      ii = i[5:0];
      return {pp, ii};
   endfunction

   function automatic int port_of(input logic [2:0] g);
      return g[2] ? 2 : (g[1] ? 1 : 0);
   endfunction

   task automatic reset_mon();
      frames = 0; last_len = 0; min_gap = 99999; byte_err = 0; bad_gnt = 0;
      first_gnt_cyc = -1; first_tx_cyc = -1;
      gnt_log.delete();
   endtask

   // One clock: sample outputs at the falling edge, then let the senders react.
   task automatic tick();
      logic [2:0] rise;
      @(negedge clk);
      cyc++;
      rise = o_gnt & ~prev_gnt;
      if (rise != 3'b000) begin
         gnt_log.push_back(port_of(rise));
         if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
      end
      if (!(o_gnt inside {3'b000, 3'b001, 3'b010, 3'b100})) bad_gnt++;
      if (o_tx_en) begin
         if (o_gnt == 3'b000) bad_gnt++;
         if (run == 0) begin
            if (first_tx_cyc < 0) first_tx_cyc = cyc;
            if (frames > 0 && low_run < min_gap) min_gap = low_run;
         end
         if (o_data !== pat(port_of(o_gnt), run)) byte_err++;
         run++;
         low_run = 0;
      end else begin
         if (run > 0) begin
            frames++;
            last_len = run;
            if (o_gnt != 3'b000) bad_gnt++;
         end
         if (o_data !== 8'h00) byte_err++;
         run = 0;
         low_run++;
      end
      for (int p = 0; p < 3; p++) begin
         if (o_gnt[p]) begin
            if (rise[p]) sent[p] = 0;
            if (!hold[p]) req[p] = 1'b0;
            if (sent[p] < len[p]) begin
               en[p] = 1'b1; dat[p] = pat(p, sent[p]); sent[p]++;
            end else begin
               en[p] = 1'b0; dat[p] = 8'h00;
            end
         end else if (stray[p]) begin
            en[p] = ~en[p]; dat[p] = 8'hEE;
         end else begin
            en[p] = 1'b0; dat[p] = 8'h00;
         end
      end
      prev_gnt = o_gnt;
   endtask

   vec_t v [7];
   int   exp_err, n, k, gnt_hi;

   initial begin
      //        req     l0  l1  l2    hold    stray   first frm len  gap err
      v[0] = '{3'b100,  0,  0,  60, 3'b000, 3'b000, 2, 1, 60,   0,  0};
      v[1] = '{3'b011, 10, 20,   0, 3'b000, 3'b000, 0, 2, 20,  14,  0};
      v[2] = '{3'b100,  0,  0,  30, 3'b000, 3'b001, 2, 1, 30,   0,  0};
      v[3] = '{3'b010,  0,  0,   0, 3'b000, 3'b000, 1, 0,  0,   0,  0};
      v[4] = '{3'b110,  0,  5,   8, 3'b000, 3'b000, 2, 2,  5,  14,  0};
      v[5] = '{3'b100,  0,  0,1600, 3'b000, 3'b000, 2, 1,1600,  0,  0};
      v[6] = '{3'b100,  0,  0,2000, 3'b000, 3'b000, 2, 1,1600,  0,  1};

      req = 3'b000; en = 3'b000; hold = 3'b000; stray = 3'b000; prev_gnt = 3'b000;
      for (int p = 0; p < 3; p++) begin dat[p] = 8'h00; len[p] = 0; sent[p] = 0; end
      cyc = 0; run = 0; low_run = 0; exp_err = 0;
      reset_mon();

      // Reset values
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_gnt", int'(o_gnt), 0);
      check("rst_tx_en", int'(o_tx_en), 0);
      check("rst_data", int'(o_data), 0);
      check("rst_busy", int'(o_busy), 0);
      check("rst_err", int'(o_err_cnt), 0);
      rst_n = 1'b1;
      repeat (2) tick();

      // Start timeout on port1, then port2 wins the next arbitration after IFG.
      reset_mon();
      len[2] = 4; hold = 3'b010; req = 3'b010;
      tick();
      check("to_gnt1", int'(o_gnt), 3'b010);
      req[2] = 1'b1;
      gnt_hi = 1;
      for (int t = 0; t < 200 && o_gnt == 3'b010; t++) begin
         tick();
         if (o_gnt == 3'b010) gnt_hi++;
      end
      check("to_gnt_cycles", gnt_hi, 64);
      exp_err = 1;
      check("to_err", int'(o_err_cnt), exp_err);
      k = 0;
      while (o_gnt != 3'b100 && k < 100) begin tick(); k++; end
      check("to_ifg_to_gnt2", k, 13);
      req[1] = 1'b0; hold = 3'b000;
      repeat (60) tick();
      check("to_frames", frames, 1);
      check("to_bytes", byte_err, 0);

      // Table of frame scenarios
      for (int i = 0; i < 7; i++) begin
         reset_mon();
         len[0] = v[i].l0; len[1] = v[i].l1; len[2] = v[i].l2;
         hold = v[i].hold; stray = v[i].stray; req = v[i].req;
         req_cyc = cyc;
         n = v[i].l0 + v[i].l1 + v[i].l2 + 80;
         for (int j = 0; j < n; j++) tick();
         exp_err += v[i].exp_err_inc;
         check($sformatf("v%0d_gnt_latency", i), first_gnt_cyc - req_cyc, 1);
         check($sformatf("v%0d_first_port", i), gnt_log.size() > 0 ? gnt_log[0] : -1, v[i].exp_first);
         check($sformatf("v%0d_frames", i), frames, v[i].exp_frames);
         check($sformatf("v%0d_len", i), last_len, v[i].exp_len);
         if (v[i].exp_frames > 0)
            check($sformatf("v%0d_tx_latency", i), first_tx_cyc - first_gnt_cyc, 1);
         if (v[i].exp_gap > 0)
            check($sformatf("v%0d_gap", i), min_gap, v[i].exp_gap);
         check($sformatf("v%0d_err", i), int'(o_err_cnt), exp_err);
         check($sformatf("v%0d_bytes", i), byte_err, 0);
         check($sformatf("v%0d_gnt_rules", i), bad_gnt, 0);
         check($sformatf("v%0d_idle", i), int'(o_busy), 0);
         stray = 3'b000;
      end

      // Withdrawal in GRANT returns straight to IDLE without IFG.
      reset_mon();
      len[0] = 0; len[1] = 0; len[2] = 3; hold = 3'b000; req = 3'b010;
      tick();
      check("wd_gnt1", int'(o_gnt), 3'b010);
      tick();
      check("wd_gnt_clear", int'(o_gnt), 0);
      check("wd_busy", int'(o_busy), 0);
      req[2] = 1'b1;
      tick();
      check("wd_next_gnt", int'(o_gnt), 3'b100);
      repeat (40) tick();
      check("wd_err", int'(o_err_cnt), exp_err);

      // Error counter saturation through repeated start timeouts on port0.
      reset_mon();
      len[0] = 0; len[1] = 0; len[2] = 0; hold = 3'b001; req = 3'b001;
      repeat (260 * 77) tick();
      check("sat_err", int'(o_err_cnt), 255);
      req = 3'b000; hold = 3'b000;
      repeat (100) tick();
      check("sat_err_hold", int'(o_err_cnt), 255);
      check("sat_idle", int'(o_busy), 0);

      // Reset mid-frame, then all three requests held: order 0,1,2,0.
      reset_mon();
      len[0] = 200; req = 3'b001;
      k = 0;
      while (run < 20 && k < 100) begin tick(); k++; end
      check("mid_in_frame", int'(o_tx_en), 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_tx_en", int'(o_tx_en), 0);
      check("mid_rst_gnt", int'(o_gnt), 0);
      check("mid_rst_busy", int'(o_busy), 0);
      check("mid_rst_err", int'(o_err_cnt), 0);
      en = 3'b000; req = 3'b111; hold = 3'b111;
      len[0] = 5; len[1] = 5; len[2] = 5;
      for (int p = 0; p < 3; p++) dat[p] = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      prev_gnt = 3'b000; run = 0; low_run = 0;
      reset_mon();
      repeat (150) tick();
      check("rr_count", gnt_log.size() >= 4 ? 1 : 0, 1);
      check("rr_0", gnt_log.size() > 0 ? gnt_log[0] : -1, 0);
      check("rr_1", gnt_log.size() > 1 ? gnt_log[1] : -1, 1);
      check("rr_2", gnt_log.size() > 2 ? gnt_log[2] : -1, 2);
      check("rr_3", gnt_log.size() > 3 ? gnt_log[3] : -1, 0);
      check("rr_gap", min_gap, 14);
      check("rr_bytes", byte_err, 0);
      check("rr_gnt_rules", bad_gnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
